shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift unit controller that accepts shift requests over a valid/ready handshake and sequences a single one-stage shift datapath through log2(N) passes, one shamt bit per cycle. It replaces a full combinational barrel shifter where area matters: one 2^k shift stage is reused each cycle under FSM control. It sits between the ALU issue logic (upstream) and the writeback path (downstream), and supports logical left, logical right, arithmetic right and rotate-left operations.

## Interface
- N, 32, data width; fixed at 32, used as a constant only.
- S, $clog2(N) = 5, shamt width and number of shift passes.

- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request (high only in IDLE).
- in_data  input  N  operand to shift.
- in_shamt  input  S  shift amount 0..N-1.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_data  output  N  shifted result.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- Internal registers: acc[N-1:0], amt[S-1:0], op[1:0], stage[S-1:0] (0..S-1).
- IDLE: in_ready=1. On in_valid && in_ready: acc<=in_data, amt<=in_shamt, op<=in_op, stage<=0, go SHIFT. Otherwise stay.
- SHIFT: each cycle, if amt[stage]=1, acc <= acc shifted by 2^stage per op; else acc unchanged. stage increments; after stage S-1 is processed go DONE. Exactly S cycles in SHIFT regardless of shamt (shamt=0 takes same latency).
- Per-stage shift by k=2^stage: SLL fills low k bits with 0; SRL fills high k bits with 0; SRA fills high k bits with acc[N-1] (sign of current acc, which equals original sign); ROL moves high k bits to low k bits.
- DONE: out_valid=1, out_data=acc. Hold until out_ready; on out_valid && out_ready go IDLE. out_data and out_valid stable while out_ready=0.
- in_valid in SHIFT/DONE is ignored (in_ready=0); no request is captured or lost-silently beyond handshake rules: upstream must hold.
- Only one request in flight; no overlap of DONE and next accept (accept earliest the cycle after the output handshake).
- out_data driven from acc in all states; only meaningful when out_valid=1.

## Timing
- Reset (async, any state, including mid-SHIFT or DONE): state=IDLE, acc=0, amt=0, op=0, stage=0; outputs in_ready=1, out_valid=0, out_data=0, busy=0 immediately on rst assertion. In-flight request is discarded.
- Accept at rising edge E0. SHIFT occupies cycles after E0..E5; out_valid rises after edge E0+S (E5 for N=32). Latency from accept edge to out_valid: S=5 cycles.
- If out_ready=1 at first DONE cycle, out_valid is high exactly one cycle; in_ready rises next cycle. Minimum request-to-request period: S+2 = 7 cycles.
- busy=1 from the cycle after accept until the cycle after output handshake.
- No combinational path from in_valid or out_ready to any output.

## Test plan
- Reset then SLL in_data=0x0000_0001, shamt=31, out_ready=1 -> out_valid exactly 5 cycles after accept edge, out_data=0x8000_0000, in_ready back high next cycle.
- SRA 0x8000_0000 shamt=4 -> 0xF800_0000; SRL same operands -> 0x0800_0000; ROL 0x8000_0001 shamt=1 -> 0x0000_0003.
- shamt=0, SLL 0xDEAD_BEEF -> 0xDEAD_BEEF after the same 5-cycle latency.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data (e.g. 0x0000_00F0 from SLL 0x0F shamt=4) stable throughout; in_ready=0; a second in_valid held meanwhile is accepted only the cycle after out_ready handshake.
- Request with in_valid pulsed during SHIFT (in_data=0xFFFF_FFFF) -> ignored; first result unaffected.
- Assert rst at SHIFT stage 2 -> outputs instantly in_ready=1, out_valid=0, out_data=0, busy=0; a fresh SRL 0x0000_0100 shamt=8 afterwards yields 0x0000_0001.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one 2^stage shift stage reused over S passes, one shamt bit per pass.
// Request/result move over valid/ready; only one request is in flight at a time.
module shift_sequencer #(
    localparam int N = 32,
    localparam int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [S-1:0] in_shamt,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_t;

    state_t              state;
    logic   [N-1:0]      acc;
    logic   [S-1:0]      amt;
    op_t                 op;
    logic   [S-1:0]      stage;

    logic   [S-1:0][N-1:0] cand;
    logic   [N-1:0]      stage_res;
    logic                stage_en;

    // Fixed-distance candidates for every pass; the pass counter picks one.
    for (genvar g = 0; g < S; g++) begin : g_stage
        localparam int K = 1 << g;
        assign cand[g] = (op == OP_SLL) ? {acc[N-1-K:0], {K{1'b0}}} :
                         (op == OP_SRL) ? {{K{1'b0}}, acc[N-1:K]} :
                         (op == OP_SRA) ? {{K{acc[N-1]}}, acc[N-1:K]} :
                                          {acc[N-1-K:0], acc[N-1:N-K]};
    end

    always_comb begin
        stage_res = cand[0];
        stage_en  = amt[0];
        for (int g = 0; g < S; g++) begin
            if (stage == S'(g)) begin
                stage_res = cand[g];
                stage_en  = amt[g];
            end
        end
    end

    assign out_data = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            amt       <= '0;
            op        <= OP_SLL;
            stage     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= in_data;
                        amt      <= in_shamt;
                        op       <= op_t'(in_op);
                        stage    <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (stage_en)
                        acc <= stage_res;
                    // Latency is S passes regardless of shamt.
                    if (stage == S'(S - 1)) begin
                        stage     <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        stage <= stage + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, each op, backpressure, ignored requests, async reset.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until out_valid (bounded); lat = cycles after the accept edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Issue one request from IDLE, check latency and result, then complete the handshake.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                          input logic [4:0] shamt, input logic [31:0] exp);
        int lat;
        in_valid = 1'b1; in_data = data; in_shamt = shamt; in_op = op;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_data"}, out_data, exp);
        tick();
        check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b0;
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_op("sra4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
        run_op("srl4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000);
        run_op("rol1",  2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003);
        run_op("sll0",  2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        run_op("rol31", 2'b11, 32'h0000_0003, 5'd31, 32'h8000_0001);
        run_op("sra31", 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
        run_op("srl17", 2'b01, 32'hFFFF_FFFF, 5'd17, 32'h0000_7FFF);

        // Backpressure: result held, a second request waits for the handshake.
        in_valid = 1'b1; in_data = 32'h0000_000F; in_shamt = 5'd4; in_op = 2'b00;
        out_ready = 1'b0;
        tick();
        in_data = 32'h0000_00F0; in_shamt = 5'd4; in_op = 2'b01;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd5);
        held = out_data;
        check("bp_data", held, 32'h0000_00F0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_data_hold", out_data, 32'h0000_00F0);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_idle_not_busy", 32'(busy), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", 32'(busy), 32'd1);
        wait_valid(lat);
        check("bp2_latency", 32'(lat), 32'd5);
        check("bp2_data", out_data, 32'h0000_000F);
        tick();

        // A request pulsed mid-shift must be ignored.
        in_valid = 1'b1; in_data = 32'h0000_0001; in_shamt = 5'd3; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd1; in_op = 2'b11;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("ign_latency", 32'(lat), 32'd3);
        check("ign_data", out_data, 32'h0000_0008);
        tick();
        tick();
        check("ign_not_captured", 32'(busy), 32'd0);
        check("ign_acc_unchanged", out_data, 32'h0000_0008);

        // Async reset at shift stage 2.
        in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd7; in_op = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("post_rst_srl8", 2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
